alu_flags: RTL and testbench
============================

Name: alu_flags

Overview:
- Datapath stage directly downstream of the 32x8 register file.
- Consumes DX_OUT/DY_OUT (or an 8-bit immediate) and computes the 8-bit ALU result, which the MCU muxes back to register-file DIN.
- Owns the architectural C, Z and I flag registers plus the shadow C/Z pair used across interrupts.
- ALU is combinational; flags update on the rising edge of CLK under control-unit strobes.

Parameters:
- WIDTH, 8, operand/result width; all arithmetic rules below are stated for 8.
- SEL_W, 4, width of the ALU operation select.

Ports:
- CLK  input  1  system clock; all flag state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand A, from register-file DX_OUT.
- DY  input  WIDTH  register operand, from register-file DY_OUT.
- IMMED  input  WIDTH  immediate operand from the instruction.
- OPY_SEL  input  1  operand B select: 0=DY, 1=IMMED.
- ALU_SEL  input  SEL_W  operation code.
- C_SET / C_CLR / C_LD  input  1 each  C flag set / clear / load from ALU.
- Z_LD  input  1  Z flag load from ALU.
- FLG_SHAD_LD  input  1  copy C/Z into shadow C/Z.
- FLG_LD_SEL  input  1  C_LD/Z_LD source: 0=ALU, 1=shadow.
- I_SET / I_CLR  input  1 each  interrupt enable set / clear.
- RESULT  output  WIDTH  combinational ALU result.
- ALU_C / ALU_Z  output  1 each  combinational carry/zero for the current op.
- C_FLAG / Z_FLAG / I_FLAG  output  1 each  registered flags.

Behaviour:
- Reset (RST_N low, asynchronous): C_FLAG, Z_FLAG, I_FLAG, SHAD_C and SHAD_Z all forced to 0 immediately, regardless of CLK. Release is sampled on the next rising CLK edge.
- Combinational outputs are not reset; they track their inputs. Zero latency from operands to RESULT, ALU_C and ALU_Z.
- B = OPY_SEL ? IMMED : DY. Cin = C_FLAG.
- Opcodes (RESULT; ALU_C):
  - 0 ADD: A+B; carry out of bit 7.
  - 1 ADDC: A+B+Cin; carry out of bit 7.
  - 2 SUB: A-B; borrow (1 when A<B unsigned).
  - 3 SUBC: A-B-Cin; borrow.
  - 4 CMP: A-B; borrow. Control unit does not write RESULT back.
  - 5 AND, 6 OR, 7 EXOR: bitwise; C=0.
  - 8 TEST: A&B; C=0. No writeback.
  - 9 LSL: {A[6:0],Cin}; C=A[7].
  - 10 LSR: {Cin,A[7:1]}; C=A[0].
  - 11 ROL: {A[6:0],A[7]}; C=A[7].
  - 12 ROR: {A[0],A[7:1]}; C=A[0].
  - 13 ASR: {A[7],A[7:1]}; C=A[0].
  - 14 MOV: B; C=Cin.
  - 15 reserved: RESULT=0, C=0.
- ALU_Z = (RESULT == 0) for every opcode. Arithmetic uses a WIDTH+1 intermediate; results wrap modulo 256.
- C_FLAG next-state priority: C_CLR > C_SET > C_LD > hold. Load source is shadow C if FLG_LD_SEL, else ALU_C.
- Z_FLAG: Z_LD loads shadow Z if FLG_LD_SEL, else ALU_Z; otherwise hold.
- Shadow: FLG_SHAD_LD captures the current-cycle C_FLAG/Z_FLAG (pre-update values). A same-cycle C_LD or Z_LD still updates the live flags. Restore plus shadow-load in the same cycle leaves the shadow value unchanged.
- I_FLAG next-state priority: I_CLR > I_SET > hold.
- ADDC/SUBC/LSL/LSR use the registered C_FLAG, never a same-cycle ALU_C. This prevents any combinational loop.

Decomposition:
- Shared package rat_pkg:
  - alu_op_t enum (the 16 codes above).
  - OPY_REG/OPY_IMM constants.
  - WIDTH default constant, shared with the register file.
- One natural sub-module, rat_alu: a purely combinational A/B/Cin/SEL -> RESULT/C/Z block.
- alu_flags instantiates rat_alu and implements operand mux, flag and shadow registers, and I flag.

Test Plan:
- Reset mid-operation: C_SET=1, clock, then drop RST_N between edges -> C_FLAG/Z_FLAG/I_FLAG drop to 0 without a clock edge.
- ADD/ADDC: A=0xFF, DY=0x01, OPY_SEL=0, ADD, C_LD=Z_LD=1 -> RESULT=0x00, after edge C=1, Z=1. Then ADDC A=0x10, IMMED=0x05 -> RESULT=0x16.
- SUB/CMP: A=0x05, IMMED=0x07, CMP -> RESULT=0xFE, ALU_C=1, ALU_Z=0. A=0x07 -> RESULT=0x00, C=0, Z=1.
- Shifts with C_FLAG=1, A=0x81:
  - LSL -> 0x03, C=1.
  - LSR -> 0xC0, C=1.
  - ROR -> 0xC0, C=1.
  - ASR -> 0xC0, C=1.
  - ROL -> 0x03, C=1.
- Interrupt save/restore: C=1, Z=0. FLG_SHAD_LD with C_CLR in the same cycle -> C=0, shadow C=1. Later FLG_LD_SEL=1, C_LD=Z_LD=1 -> C=1, Z=0 restored.
- Priority: C_SET=C_CLR=C_LD=1 -> C=0. I_SET=I_CLR=1 -> I=0. I_SET alone -> I=1, held until I_CLR.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared definitions for the ALU/flag stage and its neighbours.
package rat_pkg;

  // Datapath width, shared with the register file.
  localparam int WIDTH = 8;

  // Width of the ALU operation select.
  localparam int SEL_W = 4;

  // Operand B select values.
  localparam logic OPY_REG = 1'b0;
  localparam logic OPY_IMM = 1'b1;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_EXOR = 4'd7,
    OP_TEST = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_ASR  = 4'd13,
    OP_MOV  = 4'd14,
    OP_RSVD = 4'd15
  } alu_op_t;

endpackage

// File: rtl/rat_alu.sv
// Purely combinational ALU: operands, carry-in and opcode to result/carry/zero.
module rat_alu
  import rat_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  input  alu_op_t      op_i,
  output logic [W-1:0] result_o,
  output logic         c_o,
  output logic         z_o
);

  logic         arith_cin;
  logic [W:0]   add_w;
  logic [W:0]   sub_w;

  // Carry-in only participates in the with-carry arithmetic forms.
  assign arith_cin = cin_i & ((op_i == OP_ADDC) || (op_i == OP_SUBC));

  // One-bit-wider add/subtract; the top bit is carry out or borrow.
  always_comb begin
    add_w = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, arith_cin};
    sub_w = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, arith_cin};
  end

  // Opcode decode selecting result and carry.
  always_comb begin
    result_o = '0;
    c_o      = 1'b0;
    case (op_i)
      OP_ADD, OP_ADDC: begin
        result_o = add_w[W-1:0];
        c_o      = add_w[W];
      end
      OP_SUB, OP_SUBC, OP_CMP: begin
        result_o = sub_w[W-1:0];
        c_o      = sub_w[W];
      end
      OP_AND, OP_TEST: result_o = a_i & b_i;
      OP_OR:           result_o = a_i | b_i;
      OP_EXOR:         result_o = a_i ^ b_i;
      OP_LSL: begin
        result_o = {a_i[W-2:0], cin_i};
        c_o      = a_i[W-1];
      end
      OP_LSR: begin
        result_o = {cin_i, a_i[W-1:1]};
        c_o      = a_i[0];
      end
      OP_ROL: begin
        result_o = {a_i[W-2:0], a_i[W-1]};
        c_o      = a_i[W-1];
      end
      OP_ROR: begin
        result_o = {a_i[0], a_i[W-1:1]};
        c_o      = a_i[0];
      end
      OP_ASR: begin
        result_o = {a_i[W-1], a_i[W-1:1]};
        c_o      = a_i[0];
      end
      OP_MOV: begin
        result_o = b_i;
        c_o      = cin_i;
      end
      default: begin
        result_o = '0;
        c_o      = 1'b0;
      end
    endcase
  end

  assign z_o = (result_o == '0);

endmodule

// File: rtl/alu_flags.sv
// ALU stage with architectural C/Z/I flags and the interrupt shadow C/Z pair.
module alu_flags
  import rat_pkg::*;
#(
  parameter int WIDTH = rat_pkg::WIDTH,
  parameter int SEL_W = rat_pkg::SEL_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] DY,
  input  logic [WIDTH-1:0] IMMED,
  input  logic             OPY_SEL,
  input  logic [SEL_W-1:0] ALU_SEL,
  input  logic             C_SET,
  input  logic             C_CLR,
  input  logic             C_LD,
  input  logic             Z_LD,
  input  logic             FLG_SHAD_LD,
  input  logic             FLG_LD_SEL,
  input  logic             I_SET,
  input  logic             I_CLR,
  output logic [WIDTH-1:0] RESULT,
  output logic             ALU_C,
  output logic             ALU_Z,
  output logic             C_FLAG,
  output logic             Z_FLAG,
  output logic             I_FLAG
);

  logic [WIDTH-1:0] opy;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             i_q, i_d;
  logic             shad_c_q, shad_c_d;
  logic             shad_z_q, shad_z_d;
  logic             restore;

  // Operand B: register operand or instruction immediate.
  assign opy = (OPY_SEL == OPY_IMM) ? IMMED : DY;

  // Carry-in is always the registered C flag, so no path exists from ALU_C back into the ALU.
  rat_alu #(.W(WIDTH)) u_alu (
    .a_i      (A),
    .b_i      (opy),
    .cin_i    (c_q),
    .op_i     (alu_op_t'(ALU_SEL[3:0])),
    .result_o (RESULT),
    .c_o      (ALU_C),
    .z_o      (ALU_Z)
  );

  // A restore is any flag load sourced from the shadow pair.
  assign restore = FLG_LD_SEL & (C_LD | Z_LD);

  // Next-state for live flags, shadow pair and interrupt enable.
  always_comb begin
    c_d      = c_q;
    z_d      = z_q;
    i_d      = i_q;
    shad_c_d = shad_c_q;
    shad_z_d = shad_z_q;

    if (C_CLR)      c_d = 1'b0;
    else if (C_SET) c_d = 1'b1;
    else if (C_LD)  c_d = FLG_LD_SEL ? shad_c_q : ALU_C;

    if (Z_LD)       z_d = FLG_LD_SEL ? shad_z_q : ALU_Z;

    // Shadow captures pre-update flags, except when it is being restored from.
    if (FLG_SHAD_LD && !restore) begin
      shad_c_d = c_q;
      shad_z_d = z_q;
    end

    if (I_CLR)      i_d = 1'b0;
    else if (I_SET) i_d = 1'b1;
  end

  // Flag state registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      i_q      <= 1'b0;
      shad_c_q <= 1'b0;
      shad_z_q <= 1'b0;
    end else begin
      c_q      <= c_d;
      z_q      <= z_d;
      i_q      <= i_d;
      shad_c_q <= shad_c_d;
      shad_z_q <= shad_z_d;
    end
  end

  assign C_FLAG = c_q;
  assign Z_FLAG = z_q;
  assign I_FLAG = i_q;

endmodule

// File: tb/tb_alu_flags.sv
// Bench for alu_flags: directed plan steps followed by random vectors against an arithmetic model.
module tb_alu_flags;
  import rat_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] A, DY, IMMED;
  logic       OPY_SEL;
  logic [3:0] ALU_SEL;
  logic       C_SET, C_CLR, C_LD, Z_LD, FLG_SHAD_LD, FLG_LD_SEL, I_SET, I_CLR;
  logic [7:0] RESULT;
  logic       ALU_C, ALU_Z, C_FLAG, Z_FLAG, I_FLAG;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int m_c, m_z, m_i, m_sc, m_sz;

  // clock / reset
  always #5 CLK = ~CLK;

  alu_flags dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .DY(DY), .IMMED(IMMED),
    .OPY_SEL(OPY_SEL), .ALU_SEL(ALU_SEL),
    .C_SET(C_SET), .C_CLR(C_CLR), .C_LD(C_LD), .Z_LD(Z_LD),
    .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL),
    .I_SET(I_SET), .I_CLR(I_CLR),
    .RESULT(RESULT), .ALU_C(ALU_C), .ALU_Z(ALU_Z),
    .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .I_FLAG(I_FLAG)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU using plain integer arithmetic.
  function automatic void ref_alu(input int op, input int a, input int b, input int cin,
                                  output int res, output int c);
    int t;
    res = 0; c = 0;
    case (op)
      0:  begin t = a + b;       res = t % 256; c = (t > 255) ? 1 : 0; end
      1:  begin t = a + b + cin; res = t % 256; c = (t > 255) ? 1 : 0; end
      2, 4: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      3:  begin res = (a - b - cin + 512) % 256; c = (a < b + cin) ? 1 : 0; end
      5, 8: res = a & b;
      6:  res = a | b;
      7:  res = a ^ b;
      9:  begin res = (a * 2 + cin) % 256;          c = (a >= 128) ? 1 : 0; end
      10: begin res = a / 2 + cin * 128;            c = a % 2; end
      11: begin res = (a * 2) % 256 + a / 128;      c = (a >= 128) ? 1 : 0; end
      12: begin res = a / 2 + (a % 2) * 128;        c = a % 2; end
      13: begin res = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
      14: begin res = b; c = cin; end
      default: begin res = 0; c = 0; end
    endcase
  endfunction

  task automatic clear_strobes();
    C_SET = 0; C_CLR = 0; C_LD = 0; Z_LD = 0;
    FLG_SHAD_LD = 0; FLG_LD_SEL = 0; I_SET = 0; I_CLR = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    int r, c, z, b, pc, pz, restore;
    b = OPY_SEL ? int'(IMMED) : int'(DY);
    ref_alu(int'(ALU_SEL), int'(A), b, m_c, r, c);
    z = (r == 0) ? 1 : 0;
    #1;
    chk({tag, "_result"}, RESULT, 8'(r));
    chk({tag, "_alu_c"}, {7'b0, ALU_C}, 8'(c));
    chk({tag, "_alu_z"}, {7'b0, ALU_Z}, 8'(z));
    @(posedge CLK);
    pc = m_c; pz = m_z;
    restore = (FLG_LD_SEL && (C_LD || Z_LD)) ? 1 : 0;
    if (C_CLR)      m_c = 0;
    else if (C_SET) m_c = 1;
    else if (C_LD)  m_c = FLG_LD_SEL ? m_sc : c;
    if (Z_LD)       m_z = FLG_LD_SEL ? m_sz : z;
    if (FLG_SHAD_LD && restore == 0) begin m_sc = pc; m_sz = pz; end
    if (I_CLR)      m_i = 0;
    else if (I_SET) m_i = 1;
    #1;
    chk({tag, "_c_flag"}, {7'b0, C_FLAG}, 8'(m_c));
    chk({tag, "_z_flag"}, {7'b0, Z_FLAG}, 8'(m_z));
    chk({tag, "_i_flag"}, {7'b0, I_FLAG}, 8'(m_i));
    @(negedge CLK);
    clear_strobes();
  endtask

  task automatic set_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] dy,
                        input logic [7:0] imm, input logic opy);
    ALU_SEL = op; A = a; DY = dy; IMMED = imm; OPY_SEL = opy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 0;
    clear_strobes();
    set_op(4'd0, 8'h00, 8'h00, 8'h00, OPY_REG);
    m_c = 0; m_z = 0; m_i = 0; m_sc = 0; m_sz = 0;
    #22;
    chk("rst_c", {7'b0, C_FLAG}, 8'h00);
    chk("rst_z", {7'b0, Z_FLAG}, 8'h00);
    chk("rst_i", {7'b0, I_FLAG}, 8'h00);
    @(negedge CLK);
    RST_N = 1;

    // Reset mid-operation: set C/Z/I, then assert reset between edges.
    set_op(OP_ADD, 8'h00, 8'h00, 8'h00, OPY_REG);
    C_SET = 1; Z_LD = 1; I_SET = 1; FLG_SHAD_LD = 1;
    step("pre_rst");
    set_op(OP_ADD, 8'h00, 8'h00, 8'h00, OPY_REG);
    C_SET = 1; Z_LD = 1; FLG_SHAD_LD = 1;
    step("pre_rst2");
    #2;
    RST_N = 0;
    m_c = 0; m_z = 0; m_i = 0; m_sc = 0; m_sz = 0;
    #1;
    chk("async_rst_c", {7'b0, C_FLAG}, 8'h00);
    chk("async_rst_z", {7'b0, Z_FLAG}, 8'h00);
    chk("async_rst_i", {7'b0, I_FLAG}, 8'h00);
    @(negedge CLK);
    RST_N = 1;

    // Restoring right after reset must yield the cleared shadow pair.
    FLG_LD_SEL = 1; C_LD = 1; Z_LD = 1;
    step("rst_shadow");

    // ADD with carry out, then ADDC using the registered carry.
    set_op(OP_ADD, 8'hFF, 8'h01, 8'h00, OPY_REG);
    C_LD = 1; Z_LD = 1;
    step("add");
    chk("add_c_lit", {7'b0, C_FLAG}, 8'h01);
    chk("add_z_lit", {7'b0, Z_FLAG}, 8'h01);
    set_op(OP_ADDC, 8'h10, 8'h00, 8'h05, OPY_IMM);
    #1;
    chk("addc_lit", RESULT, 8'h16);
    step("addc");

    // CMP borrow and equal cases.
    set_op(OP_CMP, 8'h05, 8'h00, 8'h07, OPY_IMM);
    C_LD = 1; Z_LD = 1;
    step("cmp_lt");
    set_op(OP_CMP, 8'h07, 8'h00, 8'h07, OPY_IMM);
    C_LD = 1; Z_LD = 1;
    step("cmp_eq");
    set_op(OP_SUBC, 8'h00, 8'h00, 8'h00, OPY_REG);
    C_SET = 1;
    step("subc_prep");
    step("subc_wrap");

    // Shifts with C_FLAG=1, A=0x81.
    for (int op = 9; op <= 13; op++) begin
      set_op(4'(op), 8'h81, 8'h00, 8'h00, OPY_REG);
      step("shift");
    end
    set_op(OP_LSL, 8'h81, 8'h00, 8'h00, OPY_REG);
    #1;
    chk("lsl_lit", RESULT, 8'h03);
    set_op(OP_LSR, 8'h81, 8'h00, 8'h00, OPY_REG);
    #1;
    chk("lsr_lit", RESULT, 8'hC0);
    @(negedge CLK);

    // Interrupt save/restore.
    set_op(OP_OR, 8'h01, 8'h00, 8'h00, OPY_REG);
    C_SET = 1; Z_LD = 1;
    step("save_prep");
    FLG_SHAD_LD = 1; C_CLR = 1;
    step("save");
    set_op(OP_AND, 8'h0F, 8'hF0, 8'h00, OPY_REG);
    Z_LD = 1;
    step("isr_body");
    FLG_LD_SEL = 1; C_LD = 1; Z_LD = 1;
    step("restore");
    chk("restore_c_lit", {7'b0, C_FLAG}, 8'h01);
    chk("restore_z_lit", {7'b0, Z_FLAG}, 8'h00);
    // Restore combined with shadow load must keep the shadow intact.
    C_CLR = 1; Z_LD = 1; set_op(OP_RSVD, 8'h00, 8'h00, 8'h00, OPY_REG);
    step("clobber");
    FLG_LD_SEL = 1; C_LD = 1; Z_LD = 1; FLG_SHAD_LD = 1;
    step("restore_shad");
    C_CLR = 1;
    step("clobber2");
    FLG_LD_SEL = 1; C_LD = 1; Z_LD = 1;
    step("restore2");

    // Priorities.
    C_SET = 1; C_CLR = 1; C_LD = 1;
    step("c_prio");
    I_SET = 1; I_CLR = 1;
    step("i_prio");
    I_SET = 1;
    step("i_set");
    step("i_hold");
    I_CLR = 1;
    step("i_clr");

    // Random vectors.
    for (int k = 0; k < 400; k++) begin
      set_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)));
      C_SET       = ($urandom_range(0, 5) == 0);
      C_CLR       = ($urandom_range(0, 5) == 0);
      C_LD        = ($urandom_range(0, 2) == 0);
      Z_LD        = ($urandom_range(0, 2) == 0);
      FLG_SHAD_LD = ($urandom_range(0, 4) == 0);
      FLG_LD_SEL  = ($urandom_range(0, 4) == 0);
      I_SET       = ($urandom_range(0, 5) == 0);
      I_CLR       = ($urandom_range(0, 5) == 0);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
